matrix_frame_capture: RTL and testbench
=======================================

// Module: matrix_frame_capture
// PURPOSE
//  Parametrised successor to the fixed 2x2 receive capture stage. Snapshots N_ELEM
//  operand words into a holding register. Capture is triggered either by a free-running
//  period counter (timed mode) or by an external strobe (strobe mode).
//  Presents the snapshot with valid/ready and a hold timeout, feeding the inverse core.
//  Reports overruns, dropped frames and a frame count.
// PARAMETERS
//  DATA_W       16    width of one matrix element
//  N_ELEM       4     elements per frame (4 = 2x2 matrix)
//  PERIOD       1026  timed-mode period in clocks; counter runs 0..PERIOD-1 and wraps
//  CAPTURE_AT   11    counter value at which timed mode captures (< PERIOD)
//  HOLD_CYCLES  989   max cycles O_valid stays high without acceptance (>=1)
//  FCNT_W       8     frame counter width
// PORTS
//  I_sys_clk       in   1              system clock, rising edge
//  I_sys_rstn      in   1              asynchronous active-low reset
//  I_mode          in   1              0 = timed capture, 1 = strobe capture
//  I_strobe        in   1              capture request (strobe mode only)
//  I_data          in   N_ELEM*DATA_W  element k at [k*DATA_W +: DATA_W], k=0 is a11
//  I_ready         in   1              consumer accepts the frame while O_valid=1
//  I_clr_overrun   in   1              clears O_overrun
//  O_data_keep     out  N_ELEM*DATA_W  held snapshot; all zero when O_valid=0
//  O_valid         out  1              snapshot valid
//  O_drop          out  1              1-cycle pulse: frame expired unaccepted
//  O_overrun       out  1              sticky: capture event arrived while holding
//  O_frame_cnt     out  FCNT_W         frames captured, wraps modulo 2^FCNT_W
// BEHAVIOUR
//  Reset (async, while I_sys_rstn=0): period cnt=0, hold cnt=0, state ARM.
//   All outputs are 0, including O_data_keep, O_frame_cnt and O_overrun.
//  Period counter always increments and wraps PERIOD-1 -> 0, independent of mode/state.
//  Capture event (ev):
//   - timed mode: ev = (cnt==CAPTURE_AT).
//   - strobe mode: ev = I_strobe.
//   - I_mode is sampled only in ARM; a change during HOLD takes effect on return to ARM.
//  States:
//   ARM:  O_valid=0 and data zero. On ev, I_data is registered on that edge.
//         Next cycle: O_valid=1, O_frame_cnt+1, hold cnt=0, state -> HOLD.
//         Latency: 1 clock from event cycle to data valid.
//   HOLD: O_valid=1 and O_data_keep constant. Hold cnt increments each cycle.
//    a) I_ready=1 and ev=0: accept. Next cycle O_valid=0, data zero, -> ARM.
//    b) I_ready=1 and ev=1: back-to-back. New I_data loaded, O_valid stays 1,
//       frame_cnt+1, hold cnt=0, stay HOLD. No overrun is flagged.
//    c) I_ready=0 and ev=1: ev ignored, data unchanged, O_overrun<=1.
//    d) I_ready=0 and hold cnt==HOLD_CYCLES-1: timeout. O_drop pulses 1 cycle,
//       O_valid=0, data zero, -> ARM. If ev also occurs, O_overrun is set and the
//       event is not captured.
//    - Accept beats timeout when I_ready=1 on the final hold cycle.
//  O_overrun: set by (c)/(d) and cleared by I_clr_overrun. When both occur in the same
//   cycle, set wins.
//  Default parameters reproduce the legacy timing: valid for cycles 12..1000, then
//   zeroed, repeating every 1026 clocks.
//  Reset mid-HOLD: the frame is discarded immediately and no O_drop is issued.
//  All outputs are registered; there is no combinational path from input to output.
// TESTING
//  1 Timed mode, I_ready=0, I_data=0x0001_0002_0003_0004 -> O_valid rises after
//    cnt=11. It holds 989 cycles, then O_drop pulses once and data=0. Repeats at 1026.
//  2 Timed mode, I_ready=1 at cycle 20 -> O_valid=0 at 21 and frame_cnt=1.
//    No drop; next capture occurs at cnt=11 of the next period.
//  3 Strobe mode, strobe at t=5 -> valid at t=6. Strobe at t=9 with I_ready=0 ->
//    O_overrun=1 and data unchanged. I_clr_overrun at t=15 -> overrun cleared.
//  4 Strobe plus I_ready in the same HOLD cycle with new data 0xAAAA.. -> O_valid stays 1,
//    data=0xAAAA.., frame_cnt+1, overrun=0.
//  5 I_ready=1 on the timeout cycle -> accepted, no O_drop. frame_cnt wraps 255->0
//    after 256 frames (FCNT_W=8).
//  6 Assert reset mid-HOLD -> all outputs 0 asynchronously. After release,
//    capture at cnt=11.

Source files
------------

// File: rtl/matrix_frame_capture.sv
// Snapshot holding register for the inverse core: captures N_ELEM operand words on a timed
// or strobed event and presents them with valid/ready, a hold timeout and overrun tracking.
//
// state | meaning
// ARM   | waiting for a capture event, output zeroed
// HOLD  | snapshot presented, waiting for acceptance or timeout
module matrix_frame_capture #(
    parameter int DATA_W      = 16,
    parameter int N_ELEM      = 4,
    parameter int PERIOD      = 1026,
    parameter int CAPTURE_AT  = 11,
    parameter int HOLD_CYCLES = 989,
    parameter int FCNT_W      = 8
) (
    input  logic                     I_sys_clk,
    input  logic                     I_sys_rstn,
    input  logic                     I_mode,
    input  logic                     I_strobe,
    input  logic [N_ELEM*DATA_W-1:0] I_data,
    input  logic                     I_ready,
    input  logic                     I_clr_overrun,
    output logic [N_ELEM*DATA_W-1:0] O_data_keep,
    output logic                     O_valid,
    output logic                     O_drop,
    output logic                     O_overrun,
    output logic [FCNT_W-1:0]        O_frame_cnt
);

    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_CAP  = CNT_W'(CAPTURE_AT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {ARM, HOLD} state_t;

    state_t             state;
    logic [CNT_W-1:0]   period_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               mode_q;
    logic               cnt_hit;
    logic               ev_arm;
    logic               ev_hold;
    logic               overrun_set;

    assign cnt_hit = (period_cnt == CNT_CAP);
    // In HOLD the trigger source stays the one that was selected when the frame was armed
    assign ev_arm  = I_mode ? I_strobe : cnt_hit;
    assign ev_hold = mode_q ? I_strobe : cnt_hit;
    assign overrun_set = (state == HOLD) && !I_ready && ev_hold;

    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
        if (!I_sys_rstn) begin
            state       <= ARM;
            period_cnt  <= '0;
            hold_cnt    <= '0;
            mode_q      <= 1'b0;
            O_data_keep <= '0;
            O_valid     <= 1'b0;
            O_drop      <= 1'b0;
            O_overrun   <= 1'b0;
            O_frame_cnt <= '0;
        end else begin
            period_cnt <= (period_cnt == CNT_MAX) ? '0 : period_cnt + 1'b1;
            O_drop     <= 1'b0;

            if (overrun_set)
                O_overrun <= 1'b1;
            else if (I_clr_overrun)
                O_overrun <= 1'b0;

            case (state)
                ARM: begin
                    mode_q <= I_mode;
                    if (ev_arm) begin
                        O_data_keep <= I_data;
                        O_valid     <= 1'b1;
                        O_frame_cnt <= O_frame_cnt + 1'b1;
                        hold_cnt    <= '0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (I_ready) begin
                        if (ev_hold) begin
                            O_data_keep <= I_data;
                            O_frame_cnt <= O_frame_cnt + 1'b1;
                            hold_cnt    <= '0;
                        end else begin
                            O_data_keep <= '0;
                            O_valid     <= 1'b0;
                            state       <= ARM;
                        end
                    end else if (hold_cnt == HOLD_MAX) begin
                        O_data_keep <= '0;
                        O_valid     <= 1'b0;
                        O_drop      <= 1'b1;
                        state       <= ARM;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_frame_capture.sv
// Scoreboard bench for matrix_frame_capture at default parameters; cyc tracks the
// period counter value of the current cycle (0 in the first cycle after reset release).
module tb_matrix_frame_capture;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mode = 1'b0;
    logic        strobe = 1'b0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic [63:0] din = '0;
    logic [63:0] dkeep;
    logic        valid, drop, overrun;
    logic [7:0]  fcnt;

    matrix_frame_capture dut (
        .I_sys_clk    (clk),
        .I_sys_rstn   (rstn),
        .I_mode       (mode),
        .I_strobe     (strobe),
        .I_data       (din),
        .I_ready      (ready),
        .I_clr_overrun(clr),
        .O_data_keep  (dkeep),
        .O_valid      (valid),
        .O_drop       (drop),
        .O_overrun    (overrun),
        .O_frame_cnt  (fcnt)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rstn)
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  fcnt;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  exp_fcnt = '0;

    task automatic push_frame(input logic [63:0] d);
        exp_fcnt = exp_fcnt + 8'd1;
        sb.push_back({d, exp_fcnt});
    endtask

    task automatic goto_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            n_total++;
            $display("FAIL goto_cyc: reached cyc=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0; mode = 1'b0; strobe = 1'b0; ready = 1'b0; clr = 1'b0; din = '0;
        sb.delete();
        exp_fcnt = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        din = 64'hFFFF_FFFF_FFFF_FFFF; strobe = 1'b1; mode = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", valid); else n_pass++;
        n_total++; if (dkeep !== 64'd0) $display("FAIL reset_data: got %h required 0", dkeep); else n_pass++;
        n_total++; if (fcnt !== 8'd0) $display("FAIL reset_fcnt: got %0d required 0", fcnt); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b required 0", overrun); else n_pass++;
        n_total++; if (drop !== 1'b0) $display("FAIL reset_drop: got %b required 0", drop); else n_pass++;
        strobe = 1'b0; mode = 1'b0; din = '0;
    endtask

    task automatic test_timed_timeout();
        int held = 0;
        int drops = 0;
        bit stable = 1'b1;
        apply_reset();
        din = 64'h0001_0002_0003_0004;
        push_frame(din);
        goto_cyc(11);
        n_total++; if (valid !== 1'b0) $display("FAIL t1_pre_valid: got %b required 0", valid); else n_pass++;
        goto_cyc(12);
        n_total++; if (valid !== 1'b1) $display("FAIL t1_valid: got %b required 1", valid); else n_pass++;
        if (sb.size() == 0) begin n_total++; $display("FAIL t1_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t1_frame: got %h/%0d required %h/%0d", dkeep, fcnt, e.data, e.fcnt);
        end
        while (cyc <= 1000) begin
            if (valid === 1'b1) held++;
            if (dkeep !== din) stable = 1'b0;
            if (drop === 1'b1) drops++;
            @(negedge clk);
        end
        n_total++; if (held != 989) $display("FAIL t1_hold_len: got %0d required 989", held); else n_pass++;
        n_total++; if (!stable) $display("FAIL t1_stable: data changed during hold, got %h", dkeep); else n_pass++;
        n_total++; if (drops != 0) $display("FAIL t1_early_drop: got %0d required 0", drops); else n_pass++;
        n_total++; if (drop !== 1'b1) $display("FAIL t1_drop: got %b required 1", drop); else n_pass++;
        n_total++; if (valid !== 1'b0 || dkeep !== 64'd0) $display("FAIL t1_expire: got %b/%h required 0/0", valid, dkeep); else n_pass++;
        @(negedge clk);
        n_total++; if (drop !== 1'b0) $display("FAIL t1_drop_pulse: got %b required 0", drop); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL t1_overrun: got %b required 0", overrun); else n_pass++;
        push_frame(din);
        goto_cyc(1037);
        n_total++; if (valid !== 1'b0) $display("FAIL t1_pre_valid2: got %b required 0", valid); else n_pass++;
        goto_cyc(1038);
        if (sb.size() == 0) begin n_total++; $display("FAIL t1_sb2: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t1_frame2: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
    endtask

    task automatic test_timed_accept();
        bit quiet = 1'b1;
        apply_reset();
        din = 64'h1234_5678_9ABC_DEF0;
        push_frame(din);
        goto_cyc(12);
        if (sb.size() == 0) begin n_total++; $display("FAIL t2_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t2_frame: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
        goto_cyc(20);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        n_total++; if (valid !== 1'b0 || dkeep !== 64'd0) $display("FAIL t2_accept: got %b/%h required 0/0", valid, dkeep); else n_pass++;
        n_total++; if (fcnt !== 8'd1) $display("FAIL t2_fcnt: got %0d required 1", fcnt); else n_pass++;
        while (cyc < 1037) begin
            if (drop !== 1'b0 || valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        n_total++; if (!quiet || valid !== 1'b0) $display("FAIL t2_idle: drop or valid seen before next period, valid=%b", valid); else n_pass++;
        din = 64'h0F0F_0F0F_0F0F_0F0F;
        push_frame(din);
        goto_cyc(1038);
        if (sb.size() == 0) begin n_total++; $display("FAIL t2_sb2: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t2_frame2: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
    endtask

    task automatic test_strobe_overrun();
        logic [63:0] first;
        apply_reset();
        mode = 1'b1;
        first = 64'h1111_2222_3333_4444;
        din = first;
        goto_cyc(5);
        strobe = 1'b1;
        push_frame(din);
        @(negedge clk);
        strobe = 1'b0;
        if (sb.size() == 0) begin n_total++; $display("FAIL t3_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t3_frame: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
        din = 64'h5555_6666_7777_8888;
        goto_cyc(9);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        n_total++; if (overrun !== 1'b1) $display("FAIL t3_overrun: got %b required 1", overrun); else n_pass++;
        n_total++; if (dkeep !== first) $display("FAIL t3_data_kept: got %h required %h", dkeep, first); else n_pass++;
        n_total++; if (fcnt !== exp_fcnt) $display("FAIL t3_fcnt: got %0d required %0d", fcnt, exp_fcnt); else n_pass++;
        goto_cyc(15);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_total++; if (overrun !== 1'b0) $display("FAIL t3_clear: got %b required 0", overrun); else n_pass++;
        n_total++; if (valid !== 1'b1) $display("FAIL t3_still_valid: got %b required 1", valid); else n_pass++;
        strobe = 1'b1; clr = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        n_total++; if (overrun !== 1'b1) $display("FAIL t3_set_wins: got %b required 1", overrun); else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        n_total++; if (overrun !== 1'b0) $display("FAIL t3_clear2: got %b required 0", overrun); else n_pass++;
    endtask

    task automatic test_back_to_back();
        din = 64'hAAAA_AAAA_AAAA_AAAA;
        strobe = 1'b1; ready = 1'b1;
        push_frame(din);
        @(negedge clk);
        strobe = 1'b0; ready = 1'b0;
        if (sb.size() == 0) begin n_total++; $display("FAIL t4_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t4_frame: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
        n_total++; if (overrun !== 1'b0) $display("FAIL t4_overrun: got %b required 0", overrun); else n_pass++;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        n_total++; if (valid !== 1'b0 || dkeep !== 64'd0) $display("FAIL t4_accept: got %b/%h required 0/0", valid, dkeep); else n_pass++;
    endtask

    task automatic test_timeout_accept_wrap();
        int drops = 0;
        apply_reset();
        mode = 1'b1;
        din = {$urandom, $urandom};
        goto_cyc(2);
        strobe = 1'b1;
        push_frame(din);
        @(negedge clk);
        strobe = 1'b0;
        if (sb.size() == 0) begin n_total++; $display("FAIL t5_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t5_frame: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
        while (cyc < 991) begin
            if (drop === 1'b1) drops++;
            @(negedge clk);
        end
        n_total++; if (valid !== 1'b1) $display("FAIL t5_last_hold: got %b required 1", valid); else n_pass++;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL t5_accept: got %b required 0", valid); else n_pass++;
        if (drop === 1'b1) drops++;
        @(negedge clk);
        if (drop === 1'b1) drops++;
        n_total++; if (drops != 0) $display("FAIL t5_no_drop: got %0d drops required 0", drops); else n_pass++;
        for (int i = 0; i < 255; i++) begin
            din = {$urandom, $urandom};
            strobe = 1'b1;
            push_frame(din);
            @(negedge clk);
            strobe = 1'b0;
            if (sb.size() == 0) begin n_total++; $display("FAIL t5_sb_loop: scoreboard empty"); end
            else begin
                e = sb.pop_front(); n_total++;
                if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
                else $display("FAIL t5_loop_frame %0d: got %b %h/%0d required 1 %h/%0d", i, valid, dkeep, fcnt, e.data, e.fcnt);
            end
            if (i == 253) begin
                n_total++; if (fcnt !== 8'd255) $display("FAIL t5_fcnt_max: got %0d required 255", fcnt); else n_pass++;
            end
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
        n_total++; if (fcnt !== 8'd0) $display("FAIL t5_fcnt_wrap: got %0d required 0", fcnt); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL t5_idle: got %b required 0", valid); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int drops = 0;
        apply_reset();
        mode = 1'b1;
        @(negedge clk);
        din = 64'hDEAD_BEEF_CAFE_F00D;
        strobe = 1'b1;
        push_frame(din);
        @(negedge clk);
        strobe = 1'b0;
        if (sb.size() == 0) begin n_total++; $display("FAIL t6_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t6_frame: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
        #2 rstn = 1'b0;
        #1;
        n_total++; if (valid !== 1'b0 || dkeep !== 64'd0) $display("FAIL t6_async_clear: got %b/%h required 0/0", valid, dkeep); else n_pass++;
        n_total++; if (fcnt !== 8'd0 || overrun !== 1'b0 || drop !== 1'b0) $display("FAIL t6_async_status: got fcnt=%0d ovr=%b drop=%b required 0", fcnt, overrun, drop); else n_pass++;
        sb.delete();
        exp_fcnt = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        mode = 1'b0;
        din = 64'h0102_0304_0506_0708;
        push_frame(din);
        while (cyc < 11) begin
            if (drop === 1'b1) drops++;
            @(negedge clk);
        end
        n_total++; if (valid !== 1'b0) $display("FAIL t6_pre_valid: got %b required 0", valid); else n_pass++;
        @(negedge clk);
        n_total++; if (drops != 0) $display("FAIL t6_no_drop: got %0d drops required 0", drops); else n_pass++;
        if (sb.size() == 0) begin n_total++; $display("FAIL t6_sb2: scoreboard empty"); end
        else begin
            e = sb.pop_front(); n_total++;
            if (valid === 1'b1 && dkeep === e.data && fcnt === e.fcnt) n_pass++;
            else $display("FAIL t6_recapture: got %b %h/%0d required 1 %h/%0d", valid, dkeep, fcnt, e.data, e.fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_timed_timeout();
        test_timed_accept();
        test_strobe_overrun();
        test_back_to_back();
        test_timeout_accept_wrap();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
